// File: rtl/cu_mod0_1.sv
// Control unit for the BF2II stage of a radix-2^2 SDF FFT: butterfly/rotation
// controls, output valid/alert and a self-timed delay-line drain at end of stream.
module cu_mod0_1 #(
  parameter int DLY   = 8,
  parameter int BLK   = 64,
  parameter int CNT_W = $clog2(BLK)
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  input  logic alert_in,
  output logic bf_en,
  output logic rot_en,
  output logic valid_out,
  output logic alert_out,
  output logic resync,
  output logic busy
);

  localparam int B  = $clog2(DLY);
  localparam int FW = (B < 1) ? 1 : B;
  localparam logic [CNT_W-1:0] DLY_C   = CNT_W'(DLY);
  localparam logic [CNT_W-1:0] DLY_M1  = CNT_W'(DLY - 1);
  localparam logic [FW-1:0]    FL_LAST = FW'(DLY - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               primed_q, primed_d;
  logic [FW-1:0]      flush_q, flush_d;
  logic               bf_q, bf_d;
  logic               rot_q, rot_d;
  logic               vo_q, vo_d;
  logic               al_q, al_d;
  logic               rs_q, rs_d;

  logic               take;
  logic [CNT_W-1:0]   cur_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      primed_q <= 1'b0;
      flush_q  <= '0;
      bf_q     <= 1'b0;
      rot_q    <= 1'b0;
      vo_q     <= 1'b0;
      al_q     <= 1'b0;
      rs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      primed_q <= primed_d;
      flush_q  <= flush_d;
      bf_q     <= bf_d;
      rot_q    <= rot_d;
      vo_q     <= vo_d;
      al_q     <= al_d;
      rs_q     <= rs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    primed_d = primed_q;
    flush_d  = flush_q;
    bf_d     = 1'b0;
    rot_d    = 1'b0;
    vo_d     = 1'b0;
    al_d     = 1'b0;
    rs_d     = 1'b0;
    take     = 1'b0;
    cur_idx  = '0;

    case (state_q)
      IDLE: begin
        primed_d = 1'b0;
        idx_d    = '0;
        if (valid_in && alert_in) begin
          state_d = RUN;
          take    = 1'b1;
        end
      end
      RUN: begin
        if (valid_in) begin
          take    = 1'b1;
          cur_idx = alert_in ? '0 : idx_q;
          rs_d    = alert_in && (idx_q != '0);
        end else if ((idx_q == '0) && primed_q) begin
          state_d = FLUSH;
          flush_d = '0;
        end
      end
      FLUSH: begin
        if (valid_in && alert_in) begin
          state_d = RUN;
          take    = 1'b1;
          flush_d = '0;
        end else begin
          vo_d = 1'b1;
          if (flush_q == FL_LAST) begin
            state_d  = IDLE;
            primed_d = 1'b0;
            flush_d  = '0;
          end else begin
            flush_d = flush_q + FW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Accepted sample: cur_idx is its frame index (0 when alert restarts the frame)
    if (take) begin
      bf_d  = cur_idx[B];
      rot_d = cur_idx[B+1] & ~cur_idx[B];
      vo_d  = primed_q | (cur_idx >= DLY_C);
      al_d  = (cur_idx == DLY_C);
      if (cur_idx == DLY_M1) primed_d = 1'b1;
      idx_d = cur_idx + CNT_W'(1);
    end
  end

  assign bf_en     = bf_q;
  assign rot_en    = rot_q;
  assign valid_out = vo_q;
  assign alert_out = al_q;
  assign resync    = rs_q;
  assign busy      = (state_q != IDLE);

endmodule
